// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with the IF/ID pipeline register.
//
// Owns the PC and fetches from instruction memory over a req/ack handshake.
// A one-entry skid buffer absorbs a fetch that completes while decode is
// stalled. Branch/jump redirects restart fetch at a new PC. An in-flight
// request is never withdrawn: a redirect that arrives mid-request is parked
// in a target register until the old request is acked and dropped.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   imem_req       fetch request to instruction memory (registered)
//   imem_addr      byte address of the request (the PC register)
//   imem_ack       memory returns imem_rdata this cycle, ending the request
//   imem_rdata     fetched instruction, valid with imem_ack
//   stall          decode cannot accept; IF/ID holds
//   flush          invalidate IF/ID contents
//   redirect_valid taken branch/jump; fetch restarts at redirect_pc
//   redirect_pc    redirect target (word aligned)
//   id_valid       IF/ID holds a valid instruction
//   id_pc          PC of the instruction in IF/ID
//   id_instr       instruction in IF/ID
//   id_opcode      id_instr[6:0], combinational from the IF/ID register
module fetch_unit #(
  parameter int unsigned          PC_W     = 9,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [6:0]         id_opcode
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StKill = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] PcStep = PC_W'(4);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    target_q;
  logic               req_q;

  // The skid buffer is occupied exactly when the FSM is in StHold, so it
  // needs no separate valid bit.
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic               id_valid_q;
  logic [PC_W-1:0]    id_pc_q;
  logic [INSTR_W-1:0] id_instr_q;

  // Next IF/ID load candidate.
  logic               can_accept;
  logic               load_en;
  logic [PC_W-1:0]    load_pc;
  logic [INSTR_W-1:0] load_instr;

  assign can_accept = !stall || !id_valid_q;

  always_comb begin
    load_en    = 1'b0;
    load_pc    = pc_q;
    load_instr = imem_rdata;
    unique case (state_q)
      StReq: begin
        if (imem_ack && !redirect_valid && can_accept) begin
          load_en = 1'b1;
        end
      end
      StHold: begin
        if (!redirect_valid && !stall) begin
          load_en    = 1'b1;
          load_pc    = skid_pc_q;
          load_instr = skid_instr_q;
        end
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Fetch FSM, PC, redirect target and skid buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      req_q        <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              // Wrong-path data: drop it and restart at the target.
              pc_q <= redirect_pc;
            end else if (can_accept) begin
              pc_q <= pc_q + PcStep;
            end else begin
              skid_pc_q    <= pc_q;
              skid_instr_q <= imem_rdata;
              state_q      <= StHold;
              req_q        <= 1'b0;
            end
          end else if (redirect_valid) begin
            // Request must stay up until acked; remember where to go next.
            target_q <= redirect_pc;
            state_q  <= StKill;
          end
        end
        StKill: begin
          if (imem_ack) begin
            // A redirect arriving with the ack is newer than the parked one.
            pc_q    <= redirect_valid ? redirect_pc : target_q;
            state_q <= StReq;
          end else if (redirect_valid) begin
            target_q <= redirect_pc;
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= StReq;
            req_q   <= 1'b1;
          end else if (!stall) begin
            pc_q    <= pc_q + PcStep;
            state_q <= StReq;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID pipeline register: redirect/flush beat stall, stall beats load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
    end else if (redirect_valid || flush) begin
      // Zero instruction makes the decode controller drive all controls low.
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
    end else if (stall && id_valid_q) begin
      id_valid_q <= 1'b1;
    end else if (load_en) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= load_pc;
      id_instr_q <= load_instr;
    end else begin
      id_valid_q <= 1'b0;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_opcode = id_instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: fetch sequencing, stall/skid, redirect
// during a pending request, flush, PC wrap and asynchronous reset.
module tb_fetch_unit;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic [6:0]         id_opcode;

  int unsigned n_checks;
  int unsigned n_pass;

  fetch_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(9'h000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset values.
    do_reset();
    check("rst_req",    32'(imem_req), 32'h0);
    check("rst_valid",  32'(id_valid), 32'h0);
    check("rst_pc",     32'(id_pc),    32'h0);
    check("rst_instr",  id_instr,      32'h0);

    // Sequential fetch, ack every cycle.
    step();
    check("seq_req0",  32'(imem_req),  32'h1);
    check("seq_addr0", 32'(imem_addr), 32'h000);
    imem_ack = 1'b1; imem_rdata = 32'h00000013;
    step();
    check("seq_pc0",   32'(id_pc),     32'h000);
    check("seq_vld0",  32'(id_valid),  32'h1);
    check("seq_op0",   32'(id_opcode), 32'h13);
    imem_rdata = 32'h00A00093;
    step();
    check("seq_pc1",   32'(id_pc),     32'h004);
    check("seq_op1",   32'(id_opcode), 32'h13);
    imem_rdata = 32'h002081B3;
    step();
    check("seq_pc2",   32'(id_pc),     32'h008);
    check("seq_op2",   32'(id_opcode), 32'h33);
    check("seq_ins2",  id_instr,       32'h002081B3);
    check("seq_addr3", 32'(imem_addr), 32'h00C);
    imem_ack = 1'b0;

    // Stall into skid buffer.
    do_reset();
    step();
    imem_ack = 1'b1; imem_rdata = 32'h00000013;
    step();
    check("stl_pc0",   32'(id_pc),    32'h000);
    stall = 1'b1; imem_rdata = 32'h00A00093;
    step();
    check("stl_req",   32'(imem_req), 32'h0);
    check("stl_hold",  32'(id_pc),    32'h000);
    check("stl_vld",   32'(id_valid), 32'h1);
    imem_ack = 1'b0;
    step();
    check("stl_req2",  32'(imem_req), 32'h0);
    check("stl_hold2", 32'(id_pc),    32'h000);
    stall = 1'b0;
    step();
    check("stl_pc1",   32'(id_pc),     32'h004);
    check("stl_ins1",  id_instr,       32'h00A00093);
    check("stl_req3",  32'(imem_req),  32'h1);
    check("stl_addr",  32'(imem_addr), 32'h008);

    // Redirect while request at 0x008 is pending.
    redirect_valid = 1'b1; redirect_pc = 9'h040;
    step();
    redirect_valid = 1'b0;
    check("kil_addr0", 32'(imem_addr), 32'h008);
    check("kil_req0",  32'(imem_req),  32'h1);
    check("kil_vld0",  32'(id_valid),  32'h0);
    step();
    check("kil_addr1", 32'(imem_addr), 32'h008);
    step();
    check("kil_addr2", 32'(imem_addr), 32'h008);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    check("kil_drop",  32'(id_valid),  32'h0);
    check("kil_addr3", 32'(imem_addr), 32'h040);
    imem_rdata = 32'h00000013;
    step();
    check("kil_pc",    32'(id_pc),    32'h040);
    check("kil_vld",   32'(id_valid), 32'h1);
    imem_ack = 1'b0;

    // Flush together with stall.
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    check("fl_vld",  32'(id_valid),  32'h0);
    check("fl_ins",  id_instr,       32'h0);
    check("fl_op",   32'(id_opcode), 32'h0);
    check("fl_addr", 32'(imem_addr), 32'h044);

    // Redirect with ack to 0x1FC, then wrap.
    imem_ack = 1'b1; imem_rdata = 32'h0000006F;
    redirect_valid = 1'b1; redirect_pc = 9'h1FC;
    step();
    redirect_valid = 1'b0;
    check("wr_addr0", 32'(imem_addr), 32'h1FC);
    check("wr_vld0",  32'(id_valid),  32'h0);
    imem_rdata = 32'h00000013;
    step();
    check("wr_pc0",   32'(id_pc),     32'h1FC);
    check("wr_addr1", 32'(imem_addr), 32'h000);
    imem_rdata = 32'h00000033;
    step();
    check("wr_pc1",   32'(id_pc),     32'h000);
    check("wr_op1",   32'(id_opcode), 32'h33);
    imem_ack = 1'b0;

    // Asynchronous reset in the middle of a pending request.
    check("ar_pre_req", 32'(imem_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req",   32'(imem_req),  32'h0);
    check("ar_vld",   32'(id_valid),  32'h0);
    check("ar_pc",    32'(id_pc),     32'h0);
    check("ar_ins",   id_instr,       32'h0);
    check("ar_addr",  32'(imem_addr), 32'h0);
    step();
    reset = 1'b1;
    step();
    check("ar_req2",  32'(imem_req),  32'h1);
    check("ar_addr2", 32'(imem_addr), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage with IF/ID pipeline register, directly upstream of the decode Controller.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Absorbs a stalled decode stage with a one-entry skid buffer and applies branch/jump redirects.
- Presents a registered instruction, and its 7-bit opcode field, to the decode stage.

Parameters:
- PC_W, 9, PC and instruction-memory byte-address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded at reset (PC_W bits, word aligned).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  byte address of the request.
- imem_ack  in  1  memory returns imem_rdata this cycle; ends the request.
- imem_rdata  in  INSTR_W  fetched instruction, valid only with imem_ack.
- stall  in  1  decode cannot accept; IF/ID holds its contents.
- flush  in  1  invalidate IF/ID contents.
- redirect_valid  in  1  taken branch/jump: fetch restarts at redirect_pc.
- redirect_pc  in  PC_W  redirect target (word aligned).
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_pc  out  PC_W  PC of the instruction in IF/ID.
- id_instr  out  INSTR_W  instruction in IF/ID.
- id_opcode  out  7  id_instr[6:0], combinational from the register, fed to the Controller Opcode input.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_pc=0, id_instr=0, skid empty.
  - id_instr=0 makes the Controller drive all controls 0.
  - An outstanding memory request is abandoned; the memory is reset together with this block.
- States: IDLE, REQ, KILL, HOLD.
- IDLE: imem_req=0. Move to REQ at the first edge after reset deasserts.
- REQ: imem_req=1, imem_addr=pc. Both are held stable until imem_ack; a request is never withdrawn.
  - ack and redirect_valid in the same cycle: drop data, pc<=redirect_pc, stay in REQ.
  - ack, no redirect, IF/ID can accept (stall=0 or id_valid=0): IF/ID <= {pc, imem_rdata}, id_valid=1, pc<=pc+4, stay in REQ. Back-to-back acks give one instruction per cycle.
  - ack, no redirect, stall=1 and id_valid=1: skid <= {pc, imem_rdata}, go to HOLD.
  - No ack and redirect_valid: latch redirect_pc into a target register, go to KILL.
- KILL: imem_req=1, address unchanged (the old pc).
  - On ack: drop data, pc<=latched target, go to REQ.
  - A further redirect in KILL overwrites the latched target.
- HOLD: imem_req=0.
  - redirect_valid: discard skid, pc<=redirect_pc, go to REQ.
  - Else, stall=0: IF/ID <= skid, id_valid=1, pc<=pc+4, go to REQ.
- IF/ID update priority, highest first:
  1. reset
  2. redirect_valid or flush: id_valid<=0, id_instr<=0, id_pc<=0
  3. stall with id_valid=1: hold
  4. load new instruction
  5. otherwise id_valid<=0 (bubble)
- flush alone does not change pc or the FSM state. A fetch completing in the same cycle as flush is kept: skid if stall=1, otherwise it is discarded together with IF/ID. Redirect is the normal path for wrong-path removal.
- pc+4 wraps modulo 2^PC_W; no overflow indication.
- Fetch latency: instruction visible on id_* in the cycle after its imem_ack.
- Outputs are registered except id_opcode.
- No instruction is duplicated or skipped across any stall/redirect interleaving.

Test Plan:
- Reset, then ack every cycle with rdata = 0x00000013, 0x00A00093, 0x002081B3 → first req addr 0x000 one cycle after release; id_pc 0x000, 0x004, 0x008 on consecutive cycles; id_opcode 0x13, 0x13, 0x33.
- Hold stall=1 after the first instruction while memory acks addr 0x004 → FSM in HOLD, imem_req=0, id_pc stays 0x000. Release stall → id_pc=0x004, next req addr 0x008.
- Request at 0x008 pending (ack delayed 3 cycles), pulse redirect_valid with redirect_pc=0x040 → addr stays 0x008 until ack; ack data dropped, id_valid=0; next req addr 0x040; first new id_pc=0x040.
- flush and stall together with id_valid=1 → id_valid=0 and id_instr=0 (id_opcode=0) the next cycle; pc unchanged.
- PC_W=9, redirect to 0x1FC, ack twice → id_pc 0x1FC then 0x000.
- Assert reset mid-REQ with ack pending → all outputs take reset values immediately. After release, req addr=RESET_PC.
